// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter. Registered one-hot grant plus binary code,
// with an optional maximum tenure after which the grant is revoked.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no owner; the winner is picked from req by the rotating ptr
//   S_GRANT | one owner holds the resource until done, req drop or timeout
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_code,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam int unsigned HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_LAST_I);
  localparam logic        HOLD_EN     = (MAX_HOLD != 0);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic       any_req;
  logic [2:0] win;
  logic       rel_done, rel_drop, rel_to, rel_any;

  // Lowest rotated offset from ptr wins; scanning from the far end lets the
  // nearest set bit overwrite the result last.
  function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    pick_winner = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) pick_winner = idx;
    end
  endfunction

  assign any_req  = |req;
  assign win      = pick_winner(req, ptr_q);
  assign rel_done = done;
  assign rel_drop = ~req[code_q];
  assign rel_to   = HOLD_EN && (hold_q == HOLD_LAST);
  assign rel_any  = rel_done | rel_drop | rel_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= 8'd0;
      gnt_q     <= 8'd0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_GRANT;
          ptr_d   = win + 3'd1;
          hold_d  = 8'd0;
        end
      end
      S_GRANT: begin
        if (rel_any) state_d = S_IDLE;
        else         hold_d  = hold_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    code_d    = code_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = 8'b1 << win;
          code_d  = win;
          valid_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (rel_any) begin
          gnt_d     = 8'd0;
          valid_d   = 1'b0;
          // Only a pure tenure expiry counts as a revocation.
          timeout_d = rel_to & ~rel_done & ~rel_drop;
        end
      end
      default: begin
        gnt_d   = 8'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_code  = code_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule
